// File: rtl/text_box_pkg.sv
// rtl/text_box_pkg.sv - shared geometry, pipeline depth and reveal FSM encoding for the text box
package text_box_pkg;

  localparam int CELL_W     = 8;
  localparam int CELL_H     = 16;
  localparam int GRID_SIZE  = 16;
  localparam int CELL_COUNT = GRID_SIZE * GRID_SIZE;
  localparam int PIPE_DEPTH = 2;
  localparam int BOX_W      = CELL_W * GRID_SIZE;
  localparam int BOX_H      = CELL_H * GRID_SIZE;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_REVEAL = 2'd1,
    ST_DONE   = 2'd2
  } reveal_state_e;

endpackage

// File: rtl/text_reveal_fsm.sv
// rtl/text_reveal_fsm.sv - typewriter reveal counter advanced by vsync rising edges
// A gamestage change restarts the reveal from any state and wins over a coincident frame tick.
module text_reveal_fsm
  import text_box_pkg::*;
#(
  parameter int REVEAL_FRAMES = 4
) (
  input  logic       pclk,
  input  logic       rst_n,
  input  logic       vsync,
  input  logic       gamestage,
  output logic [8:0] reveal_cnt,
  output logic       reveal_done
);

  localparam logic [3:0] FRAME_LAST = 4'(REVEAL_FRAMES - 1);
  localparam logic [8:0] CNT_LAST   = 9'(CELL_COUNT - 1);

  reveal_state_e state_q, state_d;
  logic [8:0]    reveal_cnt_q, reveal_cnt_d;
  logic [3:0]    frame_cnt_q, frame_cnt_d;
  logic          vsync_q, gamestage_q, reveal_done_q;
  logic          frame_tick, restart;

  assign frame_tick = vsync & ~vsync_q;
  assign restart    = gamestage ^ gamestage_q;

  always_comb begin
    state_d      = state_q;
    reveal_cnt_d = reveal_cnt_q;
    frame_cnt_d  = frame_cnt_q;
    if (restart) begin
      state_d      = ST_REVEAL;
      reveal_cnt_d = '0;
      frame_cnt_d  = '0;
    end else if (frame_tick) begin
      case (state_q)
        ST_IDLE: begin
          state_d      = ST_REVEAL;
          reveal_cnt_d = '0;
          frame_cnt_d  = '0;
        end
        ST_REVEAL: begin
          if (frame_cnt_q == FRAME_LAST) begin
            frame_cnt_d  = '0;
            reveal_cnt_d = reveal_cnt_q + 9'd1;
            if (reveal_cnt_q == CNT_LAST) state_d = ST_DONE;
          end else begin
            frame_cnt_d = frame_cnt_q + 4'd1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      reveal_cnt_q  <= '0;
      frame_cnt_q   <= '0;
      vsync_q       <= 1'b0;
      gamestage_q   <= 1'b0;
      reveal_done_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      reveal_cnt_q  <= reveal_cnt_d;
      frame_cnt_q   <= frame_cnt_d;
      vsync_q       <= vsync;
      gamestage_q   <= gamestage;
      reveal_done_q <= (state_d == ST_DONE);
    end
  end

  assign reveal_cnt  = reveal_cnt_q;
  assign reveal_done = reveal_done_q;

endmodule

// File: rtl/text_box_ctrl.sv
// rtl/text_box_ctrl.sv - 16x16 character text box overlay on a delayed VGA stream
// Typewriter reveal is built only with TEXT_BOX_TYPEWRITER_EN; otherwise every cell is shown.
module text_box_ctrl
  import text_box_pkg::*;
#(
  parameter int          XPOS          = 64,
  parameter int          YPOS          = 64,
  parameter logic [11:0] TEXT_COLOR    = 12'hFFF,
  parameter int          REVEAL_FRAMES = 4
) (
  input  logic        pclk,
  input  logic        rst_n,
  input  logic        gamestage,
  input  logic [10:0] hcount_in,
  input  logic [10:0] vcount_in,
  input  logic        hsync_in,
  input  logic        vsync_in,
  input  logic        hblnk_in,
  input  logic        vblnk_in,
  input  logic [11:0] rgb_in,
  output logic [7:0]  char_yx,
  output logic [3:0]  char_line,
  input  logic [7:0]  char_pixels,
  output logic [10:0] hcount_out,
  output logic [10:0] vcount_out,
  output logic        hsync_out,
  output logic        vsync_out,
  output logic        hblnk_out,
  output logic        vblnk_out,
  output logic [11:0] rgb_out,
  output logic        reveal_done
);

  localparam logic [11:0] X_LO = 12'(XPOS);
  localparam logic [11:0] X_HI = 12'(XPOS + BOX_W);
  localparam logic [11:0] Y_LO = 12'(YPOS);
  localparam logic [11:0] Y_HI = 12'(YPOS + BOX_H);

  // Only the low bits of the offsets are needed, so subtract at that width.
  logic [6:0] hrel;
  logic [7:0] vrel;
  logic       in_box;

  assign hrel   = hcount_in[6:0] - 7'(XPOS);
  assign vrel   = vcount_in[7:0] - 8'(YPOS);
  assign in_box = ({1'b0, hcount_in} >= X_LO) && ({1'b0, hcount_in} < X_HI) &&
                  ({1'b0, vcount_in} >= Y_LO) && ({1'b0, vcount_in} < Y_HI);

  logic [10:0] hcount1_q, vcount1_q, hcount2_q, vcount2_q;
  logic [3:0]  sync1_q, sync2_q;
  logic [11:0] rgb1_q, rgb2_q;
  logic [7:0]  char_yx_q;
  logic [3:0]  char_line_q;
  logic [2:0]  xoff1_q, xoff2_q;
  logic        in_box1_q, in_box2_q;
  logic [7:0]  cell2_q;

  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      hcount1_q   <= '0;
      vcount1_q   <= '0;
      hcount2_q   <= '0;
      vcount2_q   <= '0;
      sync1_q     <= '0;
      sync2_q     <= '0;
      rgb1_q      <= '0;
      rgb2_q      <= '0;
      char_yx_q   <= '0;
      char_line_q <= '0;
      xoff1_q     <= '0;
      xoff2_q     <= '0;
      in_box1_q   <= 1'b0;
      in_box2_q   <= 1'b0;
      cell2_q     <= '0;
    end else begin
      hcount1_q   <= hcount_in;
      vcount1_q   <= vcount_in;
      sync1_q     <= {hsync_in, vsync_in, hblnk_in, vblnk_in};
      rgb1_q      <= rgb_in;
      char_yx_q   <= {vrel[7:4], hrel[6:3]};
      char_line_q <= vrel[3:0];
      xoff1_q     <= hrel[2:0];
      in_box1_q   <= in_box;
      hcount2_q   <= hcount1_q;
      vcount2_q   <= vcount1_q;
      sync2_q     <= sync1_q;
      rgb2_q      <= rgb1_q;
      xoff2_q     <= xoff1_q;
      in_box2_q   <= in_box1_q;
      cell2_q     <= char_yx_q;
    end
  end

  logic revealed;

`ifdef TEXT_BOX_TYPEWRITER_EN
  logic [8:0] reveal_cnt;

  text_reveal_fsm #(
    .REVEAL_FRAMES(REVEAL_FRAMES)
  ) u_reveal (
    .pclk       (pclk),
    .rst_n      (rst_n),
    .vsync      (vsync_in),
    .gamestage  (gamestage),
    .reveal_cnt (reveal_cnt),
    .reveal_done(reveal_done)
  );

  assign revealed = ({1'b0, cell2_q} < reveal_cnt);
`else
  logic reveal_done_q;

  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) reveal_done_q <= 1'b0;
    else        reveal_done_q <= 1'b1;
  end

  assign revealed    = 1'b1;
  assign reveal_done = reveal_done_q;
`endif

  // char_pixels answers the address issued in stage 1, so it lines up with stage 2.
  assign rgb_out = (in_box2_q && char_pixels[3'd7 - xoff2_q] && revealed) ? TEXT_COLOR : rgb2_q;

  assign char_yx    = char_yx_q;
  assign char_line  = char_line_q;
  assign hcount_out = hcount2_q;
  assign vcount_out = vcount2_q;
  assign {hsync_out, vsync_out, hblnk_out, vblnk_out} = sync2_q;

endmodule

// File: tb/tb_text_box_ctrl.sv
// tb/tb_text_box_ctrl.sv - directed self-checking bench for text_box_ctrl
module tb_text_box_ctrl;

  localparam int          XP  = 64;
  localparam int          YP  = 64;
  localparam logic [11:0] TXT = 12'hABC;
  localparam logic [11:0] BG  = 12'h123;

  logic        pclk = 1'b0;
  logic        rst_n = 1'b0;
  logic        gamestage = 1'b0;
  logic [10:0] hcount_in = '0, vcount_in = '0;
  logic        hsync_in = 1'b0, vsync_in = 1'b0, hblnk_in = 1'b0, vblnk_in = 1'b0;
  logic [11:0] rgb_in = '0;
  logic [7:0]  char_pixels = '0;
  logic [7:0]  char_yx;
  logic [3:0]  char_line;
  logic [10:0] hcount_out, vcount_out;
  logic        hsync_out, vsync_out, hblnk_out, vblnk_out;
  logic [11:0] rgb_out;
  logic        reveal_done;

  int tests = 0;
  int fails = 0;

  always #5 pclk = ~pclk;

  text_box_ctrl #(
    .XPOS(XP), .YPOS(YP), .TEXT_COLOR(TXT), .REVEAL_FRAMES(2)
  ) dut (
    .pclk(pclk), .rst_n(rst_n), .gamestage(gamestage),
    .hcount_in(hcount_in), .vcount_in(vcount_in),
    .hsync_in(hsync_in), .vsync_in(vsync_in), .hblnk_in(hblnk_in), .vblnk_in(vblnk_in),
    .rgb_in(rgb_in), .char_yx(char_yx), .char_line(char_line), .char_pixels(char_pixels),
    .hcount_out(hcount_out), .vcount_out(vcount_out),
    .hsync_out(hsync_out), .vsync_out(vsync_out), .hblnk_out(hblnk_out), .vblnk_out(vblnk_out),
    .rgb_out(rgb_out), .reveal_done(reveal_done)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge pclk);
    #1;
  endtask

  // Hold one pixel for two cycles so stage 2 reflects it, then check rgb_out.
  task automatic pix(input string tag, input int h, input int v, input logic [7:0] px,
                     input logic [11:0] exp);
    hcount_in   = 11'(h);
    vcount_in   = 11'(v);
    rgb_in      = BG;
    char_pixels = px;
    step();
    step();
    chk(tag, 32'(rgb_out), 32'(exp));
  endtask

  task automatic tick();
    vsync_in = 1'b1;
    step();
    vsync_in = 1'b0;
    step();
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_rgb"}, 32'(rgb_out), 32'h0);
    chk({tag, "_hc"}, 32'(hcount_out), 32'h0);
    chk({tag, "_yx"}, 32'({char_yx, char_line}), 32'h0);
    chk({tag, "_sync"}, 32'({hsync_out, vsync_out, hblnk_out, vblnk_out, reveal_done}), 32'h0);
  endtask

  initial begin
    hcount_in = 11'd300;
    vcount_in = 11'd400;
    rgb_in    = 12'hFFF;
    step();
    step();
    chk_all_zero("reset");
    rst_n = 1'b1;
    step();
`ifndef TEXT_BOX_TYPEWRITER_EN
    chk("done_after_release", 32'(reveal_done), 32'h1);
`endif

    // Exact two-cycle latency outside the box.
    hcount_in = 11'd0; vcount_in = 11'd0; rgb_in = 12'h000;
    step(); step();
    hcount_in = 11'd10; vcount_in = 11'd5; rgb_in = 12'h0A5;
    hsync_in = 1'b1; hblnk_in = 1'b1;
    step();
    chk("lat_hc_c1", 32'(hcount_out), 32'd0);
    chk("lat_rgb_c1", 32'(rgb_out), 32'h000);
    hsync_in = 1'b0; hblnk_in = 1'b0;
    step();
    chk("lat_hc_c2", 32'(hcount_out), 32'd10);
    chk("lat_vc_c2", 32'(vcount_out), 32'd5);
    chk("lat_rgb_c2", 32'(rgb_out), 32'h0A5);
    chk("lat_sync_c2", 32'({hsync_out, hblnk_out}), 32'h3);
    step();
    chk("lat_sync_c3", 32'({hsync_out, hblnk_out}), 32'h0);

    // Addressing example: cell row 2 col 2, glyph line 3, xoff 3.
    hcount_in = 11'(XP + 19); vcount_in = 11'(YP + 35);
    step();
    chk("addr_yx", 32'(char_yx), 32'h22);
    chk("addr_line", 32'(char_line), 32'd3);

`ifndef TEXT_BOX_TYPEWRITER_EN
    pix("addr_pix_on", XP + 19, YP + 35, 8'h10, TXT);
    pix("addr_pix_off", XP + 19, YP + 35, 8'h08, BG);
    pix("left_out", XP - 1, YP, 8'hFF, BG);
    pix("left_in", XP, YP, 8'h80, TXT);
    pix("right_in", XP + 127, YP, 8'h01, TXT);
    pix("right_out", XP + 128, YP, 8'hFF, BG);
    pix("top_out", XP + 8, YP - 1, 8'hFF, BG);
    pix("bottom_in", XP + 8, YP + 255, 8'h80, TXT);
    pix("bottom_out", XP + 8, YP + 256, 8'hFF, BG);

    // Asynchronous reset mid-stream, then reveal_done returns after one edge.
    hcount_in = 11'd20; rgb_in = 12'h777;
    step(); step();
    #2 rst_n = 1'b0;
    #1 chk_all_zero("mid_reset");
    @(negedge pclk);
    rst_n = 1'b1;
    step();
    chk("done_again", 32'(reveal_done), 32'h1);
`else
    pix("before_tick", XP + 3, YP, 8'h10, BG);
    tick();
    repeat (6) tick();
    pix("cell02_drawn", XP + 19, YP, 8'h10, TXT);
    pix("cell03_hidden", XP + 27, YP, 8'h10, BG);
    chk("not_done", 32'(reveal_done), 32'h0);
    repeat (505) tick();
    chk("done_before_last", 32'(reveal_done), 32'h0);
    tick();
    chk("done_set", 32'(reveal_done), 32'h1);
    pix("cellFF_drawn", XP + 123, YP + 240, 8'h10, TXT);
    repeat (3) tick();
    chk("done_held", 32'(reveal_done), 32'h1);
    pix("cellFF_held", XP + 123, YP + 240, 8'h10, TXT);

    // Restart coincident with a frame tick.
    gamestage = 1'b1; vsync_in = 1'b1;
    step();
    vsync_in = 1'b0;
    step();
    chk("restart_done", 32'(reveal_done), 32'h0);
    pix("restart_cell00", XP + 3, YP, 8'h10, BG);
    tick(); tick();
    pix("restart_cell00_on", XP + 3, YP, 8'h10, TXT);
    pix("restart_cell01_off", XP + 11, YP, 8'h10, BG);

    // Reset mid-reveal: back to IDLE until the next vsync rise.
    #2 rst_n = 1'b0;
    gamestage = 1'b0;
    #1 chk_all_zero("mid_reset");
    @(negedge pclk);
    rst_n = 1'b1;
    step(); step();
    tick(); tick();
    pix("idle_two_ticks", XP + 3, YP, 8'h10, BG);
    tick();
    pix("idle_three_ticks", XP + 3, YP, 8'h10, TXT);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
